pe_row_unit: RTL and testbench
==============================

// Module: pe_row_unit
// PURPOSE
//  Parametrised row-stationary PE, successor to the fixed 3-tap/8-bit/4-bit PE. Holds a TAPS-long
//  1-D sliding ifmap window and a loadable weight vector, computes one TAPS-tap dot product per valid
//  sample, adds the upstream partial sum and emits it with a valid flag. Ifmap is forwarded to the
//  neighbouring PE, so PEs chain into a systolic row. Adds valid handshake, fill tracking and
//  sync clear, plus selectable signed weights and saturating accumulation.
// PARAMETERS
//  DATA_W     8   ifmap sample width (always unsigned)
//  WGT_W      4   per-tap weight width
//  TAPS       3   kernel length / window depth (>=1)
//  PSUM_W     14  partial-sum width (in and out)
//  SIGNED_WGT 0   1: weights, psum_in and psum_out are two's complement; 0: all unsigned
//  SAT        0   1: clamp result to PSUM_W range; 0: wrap modulo 2^PSUM_W
// PORTS
//  clk             in  1            PE clock, rising edge
//  rst_n           in  1            async reset, active low
//  en              in  1            global enable; 0 freezes all state (incl. pipeline, outputs)
//  clear           in  1            sync: empty window, zero fill count, kill in-flight valids
//  wgt_load        in  1            latch wgt_in into weight register
//  wgt_in          in  TAPS*WGT_W   tap k at [k*WGT_W +: WGT_W]
//  ifmap_valid     in  1            ifmap_in/psum_in qualify this cycle
//  ifmap_in        in  DATA_W       ifmap sample
//  psum_in         in  PSUM_W       upstream partial sum, paired with ifmap_in
//  ifmap_valid_out out 1            forwarded valid
//  ifmap_shift_out out DATA_W       forwarded sample (1-cycle delay)
//  psum_valid      out 1            psum_out qualifies this cycle
//  psum_out        out PSUM_W       result
// BEHAVIOUR
//  - Reset: all outputs 0, weights 0, window 0, fill count 0, pipeline valids 0. Async assert,
//    takes effect mid-operation immediately; in-flight results are discarded.
//  - en=0: no register changes (wgt_load, clear, ifmap_valid ignored); outputs hold.
//  - Accept = en & ifmap_valid. On accept: window shifts (win[0]<=ifmap_in, win[k]<=win[k-1]);
//    fill count increments, saturating at TAPS; ifmap_shift_out<=ifmap_in, ifmap_valid_out<=1.
//    Otherwise with en=1: ifmap_valid_out<=0, ifmap_shift_out holds.
//  - Dot product: sum over k of wgt[k]*win[TAPS-1-k], i.e. tap 0 weights the oldest sample.
//  - Pipeline: edge E accepts sample (and registers psum_in with it); E+1 registers TAPS products;
//    E+2 registers psum_out and psum_valid. Valid issued only for accepts that leave fill==TAPS
//    (first valid at the TAPS-th accept). Throughput one result per accept; bubbles pass as
//    psum_valid=0 with psum_out holding its last value.
//  - Arithmetic: products/sum kept at full precision (DATA_W+WGT_W+1+clog2(TAPS) bits, data
//    zero-extended when SIGNED_WGT=1), then + psum_in (sign- or zero-extended), then SAT clamp
//    to [0,2^PSUM_W-1] or [-2^(PSUM_W-1),2^(PSUM_W-1)-1], else truncation to PSUM_W bits.
//  - wgt_load: weight register updated at the edge; products formed at E+1 use the weights
//    held at E+1, so a load coincident with an accept applies to that accept's result.
//  - clear: window<=0, fill<=0, stage-1/stage-2 valids<=0, ifmap_valid_out<=0; weights kept.
//    clear with accept in same cycle: clear wins, sample dropped. clear and wgt_load together: both.
//  - No backpressure: downstream must accept psum_out every valid cycle.
// TESTING
//  1 Defaults, wgt_in={4,3,1} (tap2..0), psum_in=1, stream 2,4,1,0 -> psum_valid after 3rd and
//    4th accepts +2 edges, values 19 then 8; no valid for first two accepts.
//  2 Forwarding: stream 2,4,1,0 -> ifmap_shift_out 2,4,1,0 one cycle later, ifmap_valid_out aligned.
//  3 SAT=1 vs SAT=0: weights all 15, samples 255x3, psum_in=5000 -> 16383 (SAT) / 91 (wrap).
//  4 SIGNED_WGT=1: weights {-1,0,2}=tap2..0, samples 10,20,30, psum_in=-5 -> 2*10-30-5 = -15.
//  5 en low for 4 cycles mid-stream, and a valid gap of 2 cycles -> results identical to
//    uninterrupted run, outputs frozen while en=0, no spurious psum_valid.
//  6 clear after 2 accepts, then 3 new samples -> first valid only at 3rd post-clear accept;
//    rst_n pulsed with results in flight -> all outputs 0 immediately, no stale valid afterwards.

Source files
------------

// File: rtl/pe_row_unit.sv
// -----------------------------------------------------------------------------
// pe_row_unit
//   Row-stationary processing element for a 1-D systolic row. The PE keeps a
//   TAPS-deep sliding window of ifmap samples and a loadable weight vector. For
//   every accepted sample it forms a TAPS-tap dot product, adds the upstream
//   partial sum and emits the result two edges later with a valid flag. It
//   forwards each accepted sample to the next PE after one cycle.
//
//   Pipeline, for a sample accepted at edge E:
//     E   : window shifts, psum_in captured, stage-0 valid set once window full
//     E+1 : TAPS products registered (using the weights held at E+1)
//     E+2 : psum_out / psum_valid registered (after optional saturation)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   en               global enable; 0 freezes every register
//   clear            sync flush: empties the window and kills in-flight valids
//   wgt_load, wgt_in weight load; tap k is at wgt_in[k*WGT_W +: WGT_W]
//   ifmap_valid      qualifies ifmap_in and psum_in
//   ifmap_in         ifmap sample (always unsigned)
//   psum_in          upstream partial sum, paired with ifmap_in
//   ifmap_valid_out  forwarded valid
//   ifmap_shift_out  forwarded sample (one cycle later)
//   psum_valid       psum_out qualifier
//   psum_out         result
// -----------------------------------------------------------------------------
module pe_row_unit #(
    parameter int DATA_W     = 8,
    parameter int WGT_W      = 4,
    parameter int TAPS       = 3,
    parameter int PSUM_W     = 14,
    parameter int SIGNED_WGT = 0,
    parameter int SAT        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    wgt_load,
    input  logic [TAPS*WGT_W-1:0]   wgt_in,
    input  logic                    ifmap_valid,
    input  logic [DATA_W-1:0]       ifmap_in,
    input  logic [PSUM_W-1:0]       psum_in,
    output logic                    ifmap_valid_out,
    output logic [DATA_W-1:0]       ifmap_shift_out,
    output logic                    psum_valid,
    output logic [PSUM_W-1:0]       psum_out
);

    localparam int CNT_W  = $clog2(TAPS + 1);
    // One product: unsigned data zero-extended by one bit times a weight,
    // always representable as a signed value of this width.
    localparam int PROD_W = DATA_W + WGT_W + 1;
    localparam int FULL_W = PROD_W + $clog2(TAPS);
    // One guard bit above whichever of the dot product or psum is wider, so the
    // sum never overflows before the saturation decision.
    localparam int EXT_W  = ((FULL_W > PSUM_W) ? FULL_W : PSUM_W) + 1;

    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(TAPS);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic        [WGT_W-1:0]  wgt    [TAPS];
    logic        [DATA_W-1:0] win    [TAPS];
    logic        [CNT_W-1:0]  fill;
    logic                     s0_valid;
    logic        [PSUM_W-1:0] s0_psum;
    logic signed [PROD_W-1:0] prod   [TAPS];
    logic                     s1_valid;
    logic        [PSUM_W-1:0] s1_psum;

    logic        [CNT_W-1:0]  fill_next;
    logic        [EXT_W-1:0]  acc;
    logic        [PSUM_W-1:0] result;

    // Signed product of one tap; the data operand is always non-negative.
    function automatic logic signed [PROD_W-1:0] tap_product(
        input logic [DATA_W-1:0] d,
        input logic [WGT_W-1:0]  w
    );
        logic signed [PROD_W-1:0] ds;
        logic signed [PROD_W-1:0] ws;
        ds = {{(WGT_W + 1){1'b0}}, d};
        if (SIGNED_WGT != 0) ws = {{(DATA_W + 1){w[WGT_W-1]}}, w};
        else                 ws = {{(DATA_W + 1){1'b0}}, w};
        return ds * ws;
    endfunction

    assign fill_next = (fill == FILL_FULL) ? fill : fill + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Weight register: unaffected by clear
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small window/weight arrays are flops, not RAM, so they are reset like any register.
            for (int k = 0; k < TAPS; k++) wgt[k] <= '0;
        end else if (en && wgt_load) begin
            for (int k = 0; k < TAPS; k++) wgt[k] <= wgt_in[k*WGT_W +: WGT_W];
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0: window, fill tracking, forwarding, psum capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) win[k] <= '0;
            fill            <= '0;
            ifmap_valid_out <= 1'b0;
            ifmap_shift_out <= '0;
            s0_valid        <= 1'b0;
            s0_psum         <= '0;
        end else if (en) begin
            if (clear) begin
                // clear beats a coincident sample: it is dropped entirely.
                for (int k = 0; k < TAPS; k++) win[k] <= '0;
                fill            <= '0;
                ifmap_valid_out <= 1'b0;
                s0_valid        <= 1'b0;
            end else if (ifmap_valid) begin
                // NOTE: non-blocking assignments let every tap read the pre-edge window, giving a true shift.
                win[0] <= ifmap_in;
                for (int k = 1; k < TAPS; k++) win[k] <= win[k-1];
                fill            <= fill_next;
                ifmap_shift_out <= ifmap_in;
                ifmap_valid_out <= 1'b1;
                s0_valid        <= (fill_next == FILL_FULL);
                s0_psum         <= psum_in;
            end else begin
                ifmap_valid_out <= 1'b0;
                s0_valid        <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: products. Tap 0 weights the oldest sample, win[TAPS-1].
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
            s1_valid <= 1'b0;
            s1_psum  <= '0;
        end else if (en) begin
            s1_valid <= s0_valid && !clear;
            if (s0_valid) begin
                for (int k = 0; k < TAPS; k++) prod[k] <= tap_product(win[TAPS-1-k], wgt[k]);
                s1_psum <= s0_psum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational: full-precision sum, then clamp or wrap
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns acc/result and no latch is inferred.
        acc = '0;
        for (int k = 0; k < TAPS; k++)
            acc = acc + {{(EXT_W - PROD_W){prod[k][PROD_W-1]}}, prod[k]};
        if (SIGNED_WGT != 0) acc = acc + {{(EXT_W - PSUM_W){s1_psum[PSUM_W-1]}}, s1_psum};
        else                 acc = acc + {{(EXT_W - PSUM_W){1'b0}}, s1_psum};
    end

    always_comb begin
        result = acc[PSUM_W-1:0];
        if (SAT != 0) begin
            if (SIGNED_WGT != 0) begin
                // In range only when the bits above the PSUM_W sign bit all copy it.
                if ((acc[EXT_W-1:PSUM_W-1] != '0) && (acc[EXT_W-1:PSUM_W-1] != '1))
                    result = acc[EXT_W-1] ? {1'b1, {(PSUM_W - 1){1'b0}}}
                                          : {1'b0, {(PSUM_W - 1){1'b1}}};
            end else if (acc[EXT_W-1:PSUM_W] != '0) begin
                // Unsigned operands never go negative; only the top clamp applies.
                result = '1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: output register; psum_out holds across bubbles
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_valid <= 1'b0;
            psum_out   <= '0;
        end else if (en) begin
            psum_valid <= s1_valid && !clear;
            if (s1_valid && !clear) psum_out <= result;
        end
    end

endmodule

// File: tb/tb_pe_row_unit.sv
// -----------------------------------------------------------------------------
// tb_pe_row_unit
//   Directed bench for pe_row_unit. Three instances share stimulus:
//   u_dut (defaults: unsigned, wrapping), u_sat (SAT=1), u_sgn (SIGNED_WGT=1).
//   Every expected value below is hand-computed from the dot-product definition.
// -----------------------------------------------------------------------------
module tb_pe_row_unit;

    localparam int DATA_W = 8;
    localparam int WGT_W  = 4;
    localparam int TAPS   = 3;
    localparam int PSUM_W = 14;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  clear;
    logic                  wgt_load;
    logic [TAPS*WGT_W-1:0] wgt_in;
    logic                  ifmap_valid;
    logic [DATA_W-1:0]     ifmap_in;
    logic [PSUM_W-1:0]     psum_in;

    logic                  ivo, ivo_sat, ivo_sgn;
    logic [DATA_W-1:0]     iso, iso_sat, iso_sgn;
    logic                  pv, pv_sat, pv_sgn;
    logic [PSUM_W-1:0]     po, po_sat, po_sgn;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_row_unit u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .wgt_load(wgt_load),
        .wgt_in(wgt_in), .ifmap_valid(ifmap_valid), .ifmap_in(ifmap_in), .psum_in(psum_in),
        .ifmap_valid_out(ivo), .ifmap_shift_out(iso), .psum_valid(pv), .psum_out(po)
    );

    pe_row_unit #(.SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .wgt_load(wgt_load),
        .wgt_in(wgt_in), .ifmap_valid(ifmap_valid), .ifmap_in(ifmap_in), .psum_in(psum_in),
        .ifmap_valid_out(ivo_sat), .ifmap_shift_out(iso_sat), .psum_valid(pv_sat), .psum_out(po_sat)
    );

    pe_row_unit #(.SIGNED_WGT(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .wgt_load(wgt_load),
        .wgt_in(wgt_in), .ifmap_valid(ifmap_valid), .ifmap_in(ifmap_in), .psum_in(psum_in),
        .ifmap_valid_out(ivo_sgn), .ifmap_shift_out(iso_sgn), .psum_valid(pv_sgn), .psum_out(po_sgn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs change here too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        ifmap_valid = 1'b0;
        clear       = 1'b1;
        tick();
        clear       = 1'b0;
    endtask

    task automatic load_wgt(input logic [TAPS*WGT_W-1:0] w);
        wgt_in   = w;
        wgt_load = 1'b1;
        tick();
        wgt_load = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] s1 [4];
        s1 = '{8'd2, 8'd4, 8'd1, 8'd0};

        rst_n = 1'b0; en = 1'b1; clear = 1'b0; wgt_load = 1'b0; wgt_in = '0;
        ifmap_valid = 1'b0; ifmap_in = '0; psum_in = '0;

        // ---- reset state ----
        #2;
        chk("rst_ivo", 32'(ivo), 32'd0);
        chk("rst_iso", 32'(iso), 32'd0);
        chk("rst_pv",  32'(pv),  32'd0);
        chk("rst_po",  32'(po),  32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // ---- basic stream + forwarding: weights tap2..0 = {4,3,1}, psum_in = 1 ----
        load_wgt({4'd4, 4'd3, 4'd1});
        psum_in = 14'd1;
        for (int i = 0; i < 4; i++) begin
            ifmap_valid = 1'b1;
            ifmap_in    = s1[i];
            tick();
            chk("fwd_data",  32'(iso), 32'(s1[i]));
            chk("fwd_valid", 32'(ivo), 32'd1);
            chk("no_early_valid", 32'(pv), 32'd0);
        end
        ifmap_valid = 1'b0;
        tick();
        chk("t1_pv0",  32'(pv),  32'd1);
        chk("t1_po0",  32'(po),  32'd19);   // 1*2 + 3*4 + 4*1 + 1
        chk("t1_ivo0", 32'(ivo), 32'd0);
        chk("t1_iso_hold", 32'(iso), 32'd0);
        tick();
        chk("t1_pv1",  32'(pv),  32'd1);
        chk("t1_po1",  32'(po),  32'd8);    // 1*4 + 3*1 + 4*0 + 1
        tick();
        chk("t1_bubble_pv", 32'(pv), 32'd0);
        chk("t1_bubble_po", 32'(po), 32'd8);

        // ---- saturate vs wrap: weights all 15, samples 255 x3, psum_in = 5000 ----
        do_clear();
        wgt_in      = 12'hFFF;
        wgt_load    = 1'b1;
        psum_in     = 14'd5000;
        ifmap_in    = 8'd255;
        ifmap_valid = 1'b1;
        tick();
        wgt_load = 1'b0;
        tick(); tick();
        ifmap_valid = 1'b0;
        tick(); tick();
        chk("sat_pv",  32'(pv_sat), 32'd1);
        chk("sat_po",  32'(po_sat), 32'd16383);  // 11475 + 5000 clamps
        chk("wrap_pv", 32'(pv),     32'd1);
        chk("wrap_po", 32'(po),     32'd91);     // 16475 mod 16384

        // ---- signed weights tap2..0 = {-1,0,2}, samples 10,20,30, psum_in = -5 ----
        do_clear();
        load_wgt({4'hF, 4'h0, 4'h2});
        psum_in     = 14'h3FFB;
        ifmap_valid = 1'b1;
        ifmap_in = 8'd10; tick();
        ifmap_in = 8'd20; tick();
        ifmap_in = 8'd30; tick();
        ifmap_valid = 1'b0;
        tick(); tick();
        chk("sgn_pv", 32'(pv_sgn), 32'd1);
        chk("sgn_po", 32'(po_sgn), 32'd16369);   // -15 as 14-bit two's complement
        // Same bits read unsigned: 2*10 + 15*30 + 16379 = 16849 -> wraps / clamps
        chk("uns_wrap_po", 32'(po),     32'd465);
        chk("uns_sat_po",  32'(po_sat), 32'd16383);

        // ---- enable freeze and valid gaps; result must match uninterrupted run ----
        do_clear();
        load_wgt({4'd4, 4'd3, 4'd1});
        psum_in     = 14'd1;
        ifmap_valid = 1'b1;
        ifmap_in = 8'd2; tick();
        chk("en_iso_a", 32'(iso), 32'd2);
        ifmap_in = 8'd4; tick();
        chk("en_iso_b", 32'(iso), 32'd4);
        // While disabled, sample/clear/weight-load are all ignored.
        en = 1'b0; ifmap_in = 8'd99; psum_in = 14'd77;
        clear = 1'b1; wgt_load = 1'b1; wgt_in = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frz_ivo", 32'(ivo), 32'd1);
            chk("frz_iso", 32'(iso), 32'd4);
            chk("frz_pv",  32'(pv),  32'd0);
            chk("frz_po",  32'(po),  32'd465);
        end
        clear = 1'b0; wgt_load = 1'b0; psum_in = 14'd1;
        en = 1'b1;
        ifmap_in = 8'd1; tick();
        chk("en_iso_c", 32'(iso), 32'd1);
        chk("en_pv_c",  32'(pv),  32'd0);
        ifmap_valid = 1'b0; tick();
        chk("gap_ivo", 32'(ivo), 32'd0);
        chk("gap_pv",  32'(pv),  32'd0);
        tick();
        chk("gap_pv_r0", 32'(pv), 32'd1);
        chk("gap_po_r0", 32'(po), 32'd19);
        ifmap_valid = 1'b1;
        ifmap_in = 8'd0; tick();
        chk("gap_pv_b", 32'(pv), 32'd0);
        chk("gap_po_b", 32'(po), 32'd19);
        ifmap_in = 8'd5; tick();
        chk("gap_pv_c", 32'(pv), 32'd0);
        // Freeze with two results in flight.
        en = 1'b0; ifmap_valid = 1'b0;
        tick(); tick();
        chk("frz2_pv", 32'(pv), 32'd0);
        chk("frz2_po", 32'(po), 32'd19);
        en = 1'b1;
        tick();
        chk("res_pv1", 32'(pv), 32'd1);
        chk("res_po1", 32'(po), 32'd8);
        tick();
        chk("res_pv2", 32'(pv), 32'd1);
        chk("res_po2", 32'(po), 32'd22);     // 1*1 + 3*0 + 4*5 + 1
        tick();
        chk("res_pv3", 32'(pv), 32'd0);

        // ---- clear mid-fill, then refill: valid only at 3rd post-clear accept ----
        do_clear();
        psum_in     = 14'd2;
        ifmap_valid = 1'b1;
        ifmap_in = 8'd7; tick();
        ifmap_in = 8'd9; tick();
        clear = 1'b1; ifmap_in = 8'd50; tick();
        clear = 1'b0;
        chk("clr_ivo", 32'(ivo), 32'd0);
        chk("clr_iso", 32'(iso), 32'd9);
        ifmap_in = 8'd1; tick();
        chk("clr_pv_a", 32'(pv), 32'd0);
        ifmap_in = 8'd2; tick();
        chk("clr_pv_b", 32'(pv), 32'd0);
        ifmap_in = 8'd3; tick();
        chk("clr_pv_c", 32'(pv), 32'd0);
        ifmap_valid = 1'b0; tick();
        chk("clr_pv_d", 32'(pv), 32'd0);
        tick();
        chk("clr_pv_e", 32'(pv), 32'd1);
        chk("clr_po_e", 32'(po), 32'd21);    // 1*1 + 3*2 + 4*3 + 2

        // ---- async reset with results in flight ----
        ifmap_valid = 1'b1;
        ifmap_in = 8'd4; tick();
        ifmap_in = 8'd5; tick();
        ifmap_in = 8'd6; tick();
        chk("pre_rst_pv", 32'(pv), 32'd1);
        chk("pre_rst_po", 32'(po), 32'd29);  // 1*2 + 3*3 + 4*4 + 2
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ivo", 32'(ivo), 32'd0);
        chk("arst_iso", 32'(iso), 32'd0);
        chk("arst_pv",  32'(pv),  32'd0);
        chk("arst_po",  32'(po),  32'd0);
        ifmap_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_pv", 32'(pv), 32'd0);
            chk("post_rst_po", 32'(po), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
